// File: rtl/eth_rx_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// eth_rx_frame_buffer_pkg: shared widths and write-FSM encoding
// Rev 1.0
// ============================================================================
package eth_rx_frame_buffer_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  // RAM word layout: {tlast, tkeep, tdata}
  localparam int RAM_W       = AXIS_DATA_W + AXIS_KEEP_W + 1;

  typedef enum logic [0:0] {
    ST_WRITE = 1'b0,
    ST_DROP  = 1'b1
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_sdp_ram.sv
`default_nettype none
// ============================================================================
// eth_sdp_ram: simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// ============================================================================
module eth_sdp_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 73
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Read data only changes on i_re, so the reader can stall it in place.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// eth_rx_frame_buffer: store-and-forward RX frame FIFO that drops bad frames
// and frames that do not fit. Rev 1.0
// ============================================================================
module eth_rx_frame_buffer
  import eth_rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_BITS   = 16
) (
  input  logic                   clock,
  input  logic                   async_resetn,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            frames_ok,
  output logic [CNT_BITS-1:0]    drop_bad,
  output logic [CNT_BITS-1:0]    drop_ovf
);

  localparam logic [DEPTH_LOG2:0] c_ptr_one    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] c_full_level = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CNT_BITS-1:0] c_cnt_one    = {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_commit_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [DEPTH_LOG2:0] w_used;
  logic [DEPTH_LOG2:0] w_wr_ptr_inc;
  logic                w_full;

  logic                r_s_ready;
  logic                w_beat;

  wr_state_t           r_state;
  wr_state_t           w_state_nxt;
  logic                w_store;
  logic                w_commit;
  logic                w_drop_bad;
  logic                w_drop_ovf;

  logic [31:0]         r_frames_ok;
  logic [CNT_BITS-1:0] r_drop_bad;
  logic [CNT_BITS-1:0] r_drop_ovf;

  logic                w_have;
  logic                w_out_ready;
  logic                w_ram_ready;
  logic                w_rd_en;
  logic                r_ram_vld;
  logic                r_out_vld;
  logic [RAM_W-1:0]    r_out_beat;
  logic [RAM_W-1:0]    w_ram_rdata;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_used == c_full_level);
  assign w_wr_ptr_inc = r_wr_ptr + c_ptr_one;
  assign w_beat       = s_axis_tvalid && r_s_ready;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_state <= ST_WRITE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WRITE: if (w_beat && w_full && !s_axis_tlast) w_state_nxt = ST_DROP;
      ST_DROP:  if (w_beat && s_axis_tlast)            w_state_nxt = ST_WRITE;
      default:                                         w_state_nxt = ST_WRITE;
    endcase
  end

  // A bad tlast beat is not stored: the whole frame is rewound anyway.
  always_comb begin
    w_store    = 1'b0;
    w_commit   = 1'b0;
    w_drop_bad = 1'b0;
    w_drop_ovf = 1'b0;
    if (r_state == ST_WRITE && w_beat) begin
      if (w_full) begin
        w_drop_ovf = 1'b1;
      end else if (s_axis_tlast && s_axis_tuser) begin
        w_drop_bad = 1'b1;
      end else begin
        w_store  = 1'b1;
        w_commit = s_axis_tlast;
      end
    end
  end

  // ------------------------------------------------- write pointers, counters
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_s_ready    <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_frames_ok  <= '0;
      r_drop_bad   <= '0;
      r_drop_ovf   <= '0;
    end else begin
      r_s_ready <= 1'b1;
      if (w_drop_bad || w_drop_ovf) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (w_store) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_commit) begin
        r_commit_ptr <= w_wr_ptr_inc;
        r_frames_ok  <= r_frames_ok + 32'd1;
      end
      if (w_drop_bad && !(&r_drop_bad)) r_drop_bad <= r_drop_bad + c_cnt_one;
      if (w_drop_ovf && !(&r_drop_ovf)) r_drop_ovf <= r_drop_ovf + c_cnt_one;
    end
  end

  // ----------------------------------------------------------------- storage
  eth_sdp_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (RAM_W)
  ) u_ram (
    .clk     (clock),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // ---------------------------------------------------------------- read side
  // Two-stage pipe (RAM register, output register). A slot frees as soon as
  // it is read into the pipe, and rd_ptr never passes commit_ptr.
  assign w_have      = (r_rd_ptr != r_commit_ptr);
  assign w_out_ready = !r_out_vld || m_axis_tready;
  assign w_ram_ready = !r_ram_vld || w_out_ready;
  assign w_rd_en     = w_have && w_ram_ready;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_rd_ptr   <= '0;
      r_ram_vld  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_beat <= '0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr  <= r_rd_ptr + c_ptr_one;
        r_ram_vld <= 1'b1;
      end else if (w_out_ready) begin
        r_ram_vld <= 1'b0;
      end
      if (w_out_ready) begin
        r_out_vld <= r_ram_vld;
        if (r_ram_vld) r_out_beat <= w_ram_rdata;
      end
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tdata  = r_out_beat[AXIS_DATA_W-1:0];
  assign m_axis_tkeep  = r_out_beat[AXIS_DATA_W +: AXIS_KEEP_W];
  assign m_axis_tlast  = r_out_beat[RAM_W-1];
  assign m_axis_tuser  = 1'b0;
  assign m_axis_tvalid = r_out_vld;
  assign frames_ok     = r_frames_ok;
  assign drop_bad      = r_drop_bad;
  assign drop_ovf      = r_drop_ovf;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// tb_eth_rx_frame_buffer: directed self-checking bench for eth_rx_frame_buffer
// Rev 1.0
// ============================================================================
module tb_eth_rx_frame_buffer;

  logic        clock = 1'b0;
  logic        async_resetn;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] frames_ok;
  logic [1:0]  drop_bad;
  logic [1:0]  drop_ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out    = 0;
  int          exp_ok   = 0;
  int          n0;
  logic [72:0] sb [$];
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [72:0] prev_beat;
  logic [72:0] mon_beat;

  always #5 clock = ~clock;

  // Small counters so saturation is reachable in a short run.
  eth_rx_frame_buffer #(
    .DEPTH_LOG2 (9),
    .CNT_BITS   (2)
  ) dut (
    .clock         (clock),
    .async_resetn  (async_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frames_ok     (frames_ok),
    .drop_bad      (drop_bad),
    .drop_ovf      (drop_ovf)
  );

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sends one frame; keep_it pushes its beats to the scoreboard.
  task automatic send_frame(input int len, input bit bad, input bit keep_it, input int max_gap);
    for (int i = 0; i < len; i++) begin
      logic [72:0] b;
      logic        last;
      last     = (i == len - 1);
      b[63:0]  = {$urandom, $urandom};
      b[71:64] = last ? 8'($urandom_range(1, 255)) : 8'hFF;
      b[72]    = last;
      s_axis_tdata  = b[63:0];
      s_axis_tkeep  = b[71:64];
      s_axis_tlast  = last;
      s_axis_tuser  = last && bad;
      s_axis_tvalid = 1'b1;
      if (keep_it) sb.push_back(b);
      @(posedge clock);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
      if (max_gap > 0) idle($urandom_range(1, max_gap));
    end
    if (keep_it) exp_ok++;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    c = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && c < max_cyc) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("drain_sb_empty", 73'(sb.size()), 0);
    check("drain_idle", m_axis_tvalid, 0);
  endtask

  // Output monitor: handshake at the next rising edge is decided here.
  initial begin
    forever begin
      @(negedge clock);
      if (!async_resetn) begin
        prev_stall = 1'b0;
      end else begin
        mon_beat = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) begin
          check("hold_valid", m_axis_tvalid, 1);
          check("hold_data", mon_beat, prev_beat);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_out++;
          check("tuser_zero", m_axis_tuser, 0);
          if (sb.size() == 0) check("sb_nonempty", 73'(sb.size()), 1);
          else                check("beat", mon_beat, sb.pop_front());
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = mon_beat;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    async_resetn  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_frames_ok", frames_ok, 0);
    check("rst_drop_bad", drop_bad, 0);
    check("rst_drop_ovf", drop_ovf, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    async_resetn = 1'b1;
    #1;
    check("rel_s_tready_low", s_axis_tready, 0);
    @(posedge clock);
    #1;
    check("rel_s_tready_high", s_axis_tready, 1);

    // Good frames of 1, 8, 190 beats; 1-beat frame checks read latency.
    n0 = n_out;
    send_frame(1, 0, 1, 0);
    check("lat_cycle0", m_axis_tvalid, 0);
    idle(1);
    check("lat_cycle1", m_axis_tvalid, 0);
    idle(1);
    check("lat_cycle2", m_axis_tvalid, 1);
    send_frame(8, 0, 1, 0);
    send_frame(190, 0, 1, 0);
    drain(500);
    check("good_frames_ok", frames_ok, 3);
    check("good_beats_out", 73'(n_out - n0), 199);

    // Bad 8-beat frame followed by a good 4-beat frame.
    n0 = n_out;
    send_frame(8, 1, 0, 0);
    send_frame(4, 0, 1, 0);
    drain(100);
    check("bad_drop_bad", drop_bad, 1);
    check("bad_frames_ok", frames_ok, 4);
    check("bad_beats_out", 73'(n_out - n0), 4);

    // Single-beat bad frames drive the 2-bit counter into saturation.
    send_frame(1, 1, 0, 0);
    send_frame(1, 1, 0, 0);
    idle(1);
    check("sat_drop_bad_max", drop_bad, 3);
    send_frame(1, 1, 0, 0);
    idle(1);
    check("sat_drop_bad_hold", drop_bad, 3);
    check("sat_frames_ok", frames_ok, 4);

    // Backpressure: 300 beats kept, second 300-beat frame overflows.
    m_axis_tready = 1'b0;
    n0 = n_out;
    send_frame(300, 0, 1, 0);
    send_frame(300, 0, 0, 0);
    idle(2);
    check("ovf_drop_ovf", drop_ovf, 1);
    check("ovf_frames_ok", frames_ok, 5);
    check("ovf_stalled_out", 73'(n_out - n0), 0);
    m_axis_tready = 1'b1;
    drain(1000);
    check("ovf_beats_out", 73'(n_out - n0), 300);

    // Oversized frame never fits; buffer is empty afterwards.
    n0 = n_out;
    send_frame(600, 0, 0, 0);
    idle(5);
    check("big_drop_ovf", drop_ovf, 2);
    check("big_no_output", m_axis_tvalid, 0);
    check("big_frames_ok", frames_ok, 5);
    send_frame(2, 0, 1, 0);
    drain(100);
    check("big_after_beats", 73'(n_out - n0), 2);
    exp_ok = 6;

    // Random backpressure over 1000 random-length good frames.
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) send_frame($urandom_range(1, 16), 0, 1, 2);
    rand_ready    = 1'b0;
    m_axis_tready = 1'b1;
    drain(2000);
    check("rand_frames_ok", frames_ok, 73'(exp_ok));
    check("rand_drop_ovf", drop_ovf, 2);
    check("rand_drop_bad", drop_bad, 3);

    // Reset while output is stalled and a frame is half written.
    m_axis_tready = 1'b0;
    send_frame(4, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    async_resetn  = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_axis_tvalid, 0);
    check("mid_rst_s_tready", s_axis_tready, 0);
    check("mid_rst_frames_ok", frames_ok, 0);
    check("mid_rst_drop_bad", drop_bad, 0);
    check("mid_rst_drop_ovf", drop_ovf, 0);
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    async_resetn  = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_s_tready", s_axis_tready, 1);
    n0 = n_out;
    send_frame(3, 0, 1, 0);
    drain(100);
    check("post_rst_beats_out", 73'(n_out - n0), 3);
    check("post_rst_frames_ok", frames_ok, 1);
    check("post_rst_drop_bad", drop_bad, 0);
    check("post_rst_drop_ovf", drop_ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_buffer.md
ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 9, buffer depth 2^DEPTH_LOG2 beats (512 x 64 bit = 4 KiB).
REQ-002 Parameter CNT_BITS, default 16, width of the saturating drop counters.
REQ-003 clock  in  1  single clock; all logic on the rising edge (the MAC user clock, gt_clock, at integration).
REQ-004 async_resetn  in  1  asynchronous assert, active-low reset.
REQ-005 s_axis_tdata/tkeep/tlast/tuser/tvalid  in  64/8/1/1/1  RX beats from the MAC; tuser=1 on the tlast beat marks a bad frame (FCS error).
REQ-006 s_axis_tready  out  1  always 1 after reset; the MAC cannot be backpressured.
REQ-007 m_axis_tdata/tkeep/tlast/tvalid  out  64/8/1/1  frame stream toward the DMA core.
REQ-008 m_axis_tuser  out  1  constant 0; only good frames are forwarded.
REQ-009 m_axis_tready  in  1  downstream ready.
REQ-010 frames_ok  out  32  wrapping count of committed frames.
REQ-011 drop_bad  out  CNT_BITS  saturating count of frames dropped for tuser=1.
REQ-012 drop_ovf  out  CNT_BITS  saturating count of frames dropped for lack of space.

Function
REQ-013 Store-and-forward operation: no beat of a frame appears on m_axis before that frame's tlast beat has been accepted and committed.
REQ-014 Pointers are DEPTH_LOG2+1 bits: wr_ptr (speculative), commit_ptr, rd_ptr; used = wr_ptr - rd_ptr; full when used = 2^DEPTH_LOG2.
REQ-015 Write FSM states: WRITE (default after reset) and DROP.
REQ-016 In WRITE, an s_axis beat with the buffer not full is stored and wr_ptr increments.
REQ-017 In WRITE, a beat with tlast=1 and tuser=0 moves commit_ptr to the post-write wr_ptr on the next edge and increments frames_ok.
REQ-018 In WRITE, a beat with tlast=1 and tuser=1 rewinds wr_ptr to commit_ptr and increments drop_bad.
REQ-019 In WRITE, a beat arriving while the buffer is full rewinds wr_ptr to commit_ptr and increments drop_ovf. If that beat has tlast=0, the FSM goes to DROP. If it has tlast=1, the FSM stays in WRITE.
REQ-020 In DROP, all beats are discarded; the tlast beat returns the FSM to WRITE. No counter changes.
REQ-021 A frame longer than 2^DEPTH_LOG2 beats is always dropped as overflow.
REQ-022 A single-beat frame (first beat has tlast=1) is legal and is handled as in REQ-017/018.
REQ-023 Read side: m_axis_tvalid is asserted whenever the committed data is not exhausted (rd_ptr != commit_ptr, including prefetched output).
REQ-024 Read side is a registered RAM read with an output stage; it sustains 1 beat/cycle while m_axis_tready=1.
REQ-025 Read latency: the first beat of a frame is valid exactly 2 cycles after its tlast handshake when the buffer was empty.
REQ-026 m_axis data is held stable while tvalid=1 and tready=0.
REQ-027 Simultaneous commit and read, or rewind and read, in the same cycle are legal. Reads never pass commit_ptr.
REQ-028 Space freed by a read becomes usable by the write side on the next cycle.
REQ-029 Counters drop_bad and drop_ovf saturate at all-ones; frames_ok wraps.

Reset
REQ-030 On async_resetn=0, asynchronously: all pointers 0, FSM=WRITE, m_axis_tvalid=0, counters 0, s_axis_tready=0.
REQ-031 s_axis_tready goes to 1 on the first clock after release.
REQ-032 Reset mid-frame discards all buffered data.
REQ-033 After reset, the first accepted beat is treated as the start of a frame.
REQ-034 RAM contents are not reset.

Structure
REQ-035 A shared package holds: AXIS data width 64, keep width 8, and the write-FSM state enum.
REQ-036 One sub-module, eth_sdp_ram: a simple dual-port RAM, width 73 (data+keep+last), registered read, no reset.

Verification
REQ-037 Stream three good frames of 1, 8 and 190 beats, tready=1 -> identical data/tkeep/tlast out, frames_ok=3, first output beat 2 cycles after the 1-beat tlast.
REQ-038 Send an 8-beat frame with tuser=1 on tlast, then a 4-beat good frame -> only the 4-beat frame appears; drop_bad=1.
REQ-039 Hold tready=0 and send frames of 300 then 300 beats (DEPTH_LOG2=9) -> first frame kept, second dropped. Result: drop_ovf=1, FSM in DROP until tlast; after tready=1, exactly 300 beats out.
REQ-040 Send a 600-beat frame with DEPTH_LOG2=9 -> nothing output, drop_ovf=1, buffer empty afterward.
REQ-041 Toggle tready randomly (50%) over 1000 random-length good frames -> output equals a scoreboard, no stalls beyond tready, data stable under backpressure.
REQ-042 Assert async_resetn=0 mid-frame (beat 5 of 10) and mid-output, then send a good 3-beat frame -> all outputs at reset values, only the 3-beat frame emerges, counters reflect only post-reset frames.
